// File: rtl/ex_muldiv_seq_if.sv
// EX-stage mul/div request/response bundle; master drives the op, slave returns stall/done/result.
// Combinational interface only: no latency, stall_out is the slave's backpressure to the pipeline.
interface ex_muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic            flush;
    logic            stall_out;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, opa, opb, flush,
        input  stall_out, done, result
    );

    modport slave (
        input  start, funct3, opa, opb, flush,
        output stall_out, done, result
    );
endinterface

// File: rtl/ex_muldiv_seq.sv
// RV32M iterative shift-add multiplier / restoring divider: done XLEN+1 cycles after start (1 for div special cases).
// Backpressure: stall_out holds the pipeline from the accepting cycle until DONE; flush aborts at any point.
module ex_muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    ex_muldiv_seq_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [XLEN-1:0]   r_acc;
    logic [XLEN-1:0]   r_mpl;
    logic [XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]   r_result;
    logic [2:0]        r_funct3;
    logic              r_neg;
    logic              r_rneg;
    logic              r_spec;
    logic [CW-1:0]     r_cnt;

    logic              w_accept;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_spec_val;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_sh;
    logic              w_div_ge;
    logic [XLEN-1:0]   w_div_diff;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_final;
    logic              w_done;

    assign w_accept = (r_state == S_IDLE) && bus.start && !bus.flush;

    always_comb begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
        case (bus.funct3)
            3'b010:                 w_b_signed = 1'b0;
            3'b011, 3'b101, 3'b111: begin
                w_a_signed = 1'b0;
                w_b_signed = 1'b0;
            end
            default: ;
        endcase
    end

    assign w_a_neg = w_a_signed && bus.opa[XLEN-1];
    assign w_b_neg = w_b_signed && bus.opb[XLEN-1];
    assign w_a_mag = w_a_neg ? -bus.opa : bus.opa;
    assign w_b_mag = w_b_neg ? -bus.opb : bus.opb;

    // Divide-by-zero and signed INT_MIN/-1 skip the iteration; the answer is parked in r_acc.
    assign w_div0     = (bus.opb == '0);
    assign w_ovf      = w_a_signed && (bus.opa == {1'b1, {(XLEN-1){1'b0}}}) && (bus.opb == '1);
    assign w_special  = bus.funct3[2] && (w_div0 || w_ovf);
    assign w_spec_val = w_div0 ? (bus.funct3[1] ? bus.opa : '1)
                               : (bus.funct3[1] ? '0 : bus.opa);

    assign w_mul_sum  = {1'b0, r_acc} + (r_mpl[0] ? {1'b0, r_mcand} : {(XLEN+1){1'b0}});
    assign w_div_sh   = {r_acc, r_mpl[XLEN-1]};
    assign w_div_ge   = (w_div_sh >= {1'b0, r_mcand});
    assign w_div_diff = w_div_sh[XLEN-1:0] - r_mcand;

    always_comb begin
        w_prod  = {r_acc, r_mpl};
        if (r_neg) begin
            w_prod = -w_prod;
        end
        w_quo   = r_neg  ? -r_mpl : r_mpl;
        w_rem   = r_rneg ? -r_acc : r_acc;
        w_final = '0;
        if (r_spec) begin
            w_final = r_acc;
        end else begin
            case (r_funct3)
                3'b000:                 w_final = w_prod[XLEN-1:0];
                3'b001, 3'b010, 3'b011: w_final = w_prod[2*XLEN-1:XLEN];
                3'b100, 3'b101:         w_final = w_quo;
                default:                w_final = w_rem;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        bus.stall_out = 1'b0;
        if (bus.flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start) begin
                    if (w_special)          w_next = S_DONE;
                    else if (bus.funct3[2]) w_next = S_DIV;
                    else                    w_next = S_MUL;
                end
                S_MUL, S_DIV: if (r_cnt == CW'(1)) w_next = S_DONE;
                default: w_next = S_IDLE;
            endcase
        end
        case (r_state)
            S_IDLE:       bus.stall_out = bus.start && !bus.flush;
            S_MUL, S_DIV: bus.stall_out = 1'b1;
            default:      bus.stall_out = 1'b0;
        endcase
    end

    assign w_done     = (r_state == S_DONE) && !bus.flush;
    assign bus.done   = w_done;
    assign bus.result = w_done ? w_final : r_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mpl    <= '0;
            r_mcand  <= '0;
            r_result <= '0;
            r_funct3 <= '0;
            r_neg    <= 1'b0;
            r_rneg   <= 1'b0;
            r_spec   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_funct3 <= bus.funct3;
                r_cnt    <= CW'(XLEN);
                r_spec   <= w_special;
                r_mpl    <= w_a_mag;
                r_mcand  <= w_b_mag;
                r_acc    <= w_special ? w_spec_val : '0;
                r_neg    <= w_a_neg ^ w_b_neg;
                r_rneg   <= w_a_neg;
            end else if (!bus.flush && r_state == S_MUL) begin
                r_acc <= w_mul_sum[XLEN:1];
                r_mpl <= {w_mul_sum[0], r_mpl[XLEN-1:1]};
                r_cnt <= r_cnt - CW'(1);
            end else if (!bus.flush && r_state == S_DIV) begin
                r_acc <= w_div_ge ? w_div_diff : w_div_sh[XLEN-1:0];
                r_mpl <= {r_mpl[XLEN-2:0], w_div_ge};
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_done) begin
                r_result <= w_final;
            end
        end
    end
endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Bench for ex_muldiv_seq: table of ops plus flush / reset / ignored-start sequences.
// Expected results are queued at start and popped when done is seen.
module tb_ex_muldiv_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_muldiv_seq_if #(.XLEN(32)) bus ();
    ex_muldiv_seq #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       nm;
    } vec_t;

    vec_t        vt[$];
    logic [31:0] exp_q[$];
    string       nm_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] last_exp;
    logic [31:0] mon_e;
    string       mon_nm;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp, input int lat, input string nm);
        vec_t v;
        v.f3 = f3; v.a = a; v.b = b; v.exp = exp; v.lat = lat; v.nm = nm;
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: got done with result %h expected no done", bus.result);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_nm = nm_q.pop_front();
                chk({mon_nm, " result"}, bus.result, mon_e);
            end
        end
    end

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string nm, input bit noise);
        int k;
        bit seen;
        bit stall_bad;
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.opa    = a;
        bus.opb    = b;
        #1;
        chk({nm, " stall_at_start"}, {31'd0, bus.stall_out}, 32'd1);
        exp_q.push_back(exp);
        nm_q.push_back(nm);
        k = 0;
        seen = 0;
        stall_bad = 0;
        while (!seen && k < 60) begin
            @(posedge clk); #1;
            k++;
            if (k == 1) begin
                bus.opa = $urandom;
                bus.opb = $urandom;
            end
            if (bus.done) begin
                seen = 1;
            end else begin
                if (bus.stall_out !== 1'b1) stall_bad = 1;
                bus.start  = noise && (k == 1 || k == 20);
                bus.funct3 = 3'b100;
                bus.opb    = '0;
            end
        end
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s timeout: got no done in %0d cycles expected done at %0d", nm, k, lat);
            exp_q.delete();
            nm_q.delete();
            bus.start = 1'b0;
        end else begin
            chk({nm, " latency"}, 32'(k), 32'(lat));
            if (lat > 1) chk({nm, " stall_busy_drop"}, {31'd0, stall_bad}, 32'd0);
            chk({nm, " stall_in_done"}, {31'd0, bus.stall_out}, 32'd0);
            last_exp  = exp;
            bus.start = noise;
            @(posedge clk); #1;
            bus.start = 1'b0;
            chk({nm, " result_hold"}, bus.result, last_exp);
        end
    endtask

    initial begin
        vt.push_back(mk(3'b000, 32'd7,        32'd6,        32'd42,         33, "MUL 7*6"));
        vt.push_back(mk(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000,   33, "MULH -1*-1"));
        vt.push_back(mk(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,   33, "MULHU max*max"));
        vt.push_back(mk(3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF,   33, "MULHSU -1*2"));
        vt.push_back(mk(3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1,   33, "MUL -3*5"));
        vt.push_back(mk(3'b001, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF,   33, "MULH -3*5"));
        vt.push_back(mk(3'b001, 32'h80000000, 32'h80000000, 32'h40000000,   33, "MULH min*min"));
        vt.push_back(mk(3'b011, 32'h80000000, 32'h80000000, 32'h40000000,   33, "MULHU 2^31*2^31"));
        vt.push_back(mk(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD,   33, "DIV -7/2"));
        vt.push_back(mk(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF,   33, "REM -7/2"));
        vt.push_back(mk(3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD,   33, "DIV 7/-2"));
        vt.push_back(mk(3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,          33, "REM 7/-2"));
        vt.push_back(mk(3'b101, 32'd100,      32'd7,        32'd14,         33, "DIVU 100/7"));
        vt.push_back(mk(3'b111, 32'd100,      32'd7,        32'd2,          33, "REMU 100/7"));
        vt.push_back(mk(3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,          33, "DIVU 2^31/max"));
        vt.push_back(mk(3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,   33, "REMU 2^31/max"));
        vt.push_back(mk(3'b100, 32'd5,        32'd0,        32'hFFFFFFFF,    1, "DIV 5/0"));
        vt.push_back(mk(3'b110, 32'd5,        32'd0,        32'd5,           1, "REM 5/0"));
        vt.push_back(mk(3'b101, 32'd5,        32'd0,        32'hFFFFFFFF,    1, "DIVU 5/0"));
        vt.push_back(mk(3'b111, 32'd5,        32'd0,        32'd5,           1, "REMU 5/0"));
        vt.push_back(mk(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,    1, "DIV min/-1"));
        vt.push_back(mk(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,           1, "REM min/-1"));

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = '0;
        bus.opa    = '0;
        bus.opb    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset stall_out", {31'd0, bus.stall_out}, 32'd0);
        chk("reset done", {31'd0, bus.done}, 32'd0);
        chk("reset result", bus.result, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vt[i]) begin
            run_op(vt[i].f3, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat, vt[i].nm, 1'b0);
        end

        // Flush in the middle of a divide: no done, result untouched, next op runs normally.
        bus.start  = 1'b1;
        bus.funct3 = 3'b100;
        bus.opa    = 32'd100;
        bus.opb    = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("flush busy_before", {31'd0, bus.stall_out}, 32'd1);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush idle_after", {31'd0, bus.stall_out}, 32'd0);
        chk("flush result_kept", bus.result, last_exp);
        repeat (40) @(posedge clk);
        #1;
        chk("flush result_still_kept", bus.result, last_exp);
        run_op(3'b000, 32'd3, 32'd3, 32'd9, 33, "MUL 3*3 after flush", 1'b0);

        // Reset in the middle of a multiply.
        bus.start  = 1'b1;
        bus.funct3 = 3'b000;
        bus.opa    = 32'h1234;
        bus.opb    = 32'h5678;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst stall_out", {31'd0, bus.stall_out}, 32'd0);
        chk("midrst done", {31'd0, bus.done}, 32'd0);
        chk("midrst result", bus.result, 32'd0);
        rst = 1'b0;
        last_exp = '0;
        @(posedge clk); #1;

        // Start pulses while busy and in DONE must be dropped.
        run_op(3'b000, 32'd3, 32'd4, 32'd12, 33, "MUL 3*4 with busy starts", 1'b1);
        repeat (40) @(posedge clk);
        #1;
        chk("ignored_start idle_stall", {31'd0, bus.stall_out}, 32'd0);
        chk("ignored_start result_kept", bus.result, 32'd12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
